regfile_bank: RTL and testbench
===============================

// Module: regfile_bank
// PURPOSE
// - Parametrised register bank for the MIPS core.
// - Generalises the flat 32x32 register flop: configurable width, depth and
//   read-port count; write enable; hardwired zero register; write-to-read
//   bypass; per-register busy scoreboard; full-state dump for debug and trace.
// - Sits between decode (read/busy) and writeback (write).
// PARAMETERS
// - DATA_W    32                  register width in bits
// - NUM_REGS  32                  number of registers; power of 2, >= 2
// - ADDR_W    $clog2(NUM_REGS)    register index width
// - NUM_RD    2                   number of combinational read ports, >= 1
// - BYPASS    1                   1: same-cycle write data forwarded to reads
// - ZERO_REG  1                   1: register 0 reads 0, ignores writes, never busy
// PORTS
// - clk        in   1                 clock; rising edge active
// - rst        in   1                 asynchronous reset, active-high
// - wr_en      in   1                 write strobe from writeback
// - wr_addr    in   ADDR_W            write index
// - wr_data    in   DATA_W            write data
// - rd_addr    in   NUM_RD*ADDR_W     read indices; port p uses bits [p*ADDR_W +: ADDR_W]
// - rd_data    out  NUM_RD*DATA_W     read data; port p uses bits [p*DATA_W +: DATA_W]
// - busy_set   in   1                 decode marks a destination as pending
// - busy_addr  in   ADDR_W            index to mark
// - busy       out  NUM_REGS          scoreboard; bit i = register i awaits a write
// - dump_regs  out  NUM_REGS*DATA_W   current contents of every register
// BEHAVIOUR
// Reset
// - rst high clears every register and every busy bit to 0 immediately, not waiting for clk.
// - Outputs follow at once: busy = 0, dump_regs = 0, rd_data = 0.
// - Exception: BYPASS=1 with wr_en high while rst is high forwards wr_data to
//   matching read ports.
// - Writes are suppressed while rst is high.
// - Asserting rst mid-operation discards any pending write and clears all busy state.
// Write
// - On a rising clk edge with wr_en=1, reg[wr_addr] <= wr_data.
// - The new value is visible on dump_regs and non-bypassed reads from the next cycle.
// - ZERO_REG=1 and wr_addr=0: the write is dropped and reg[0] stays 0.
// Read
// - Latency 0: rd_data[p] = reg[rd_addr[p]], combinational.
// - ZERO_REG=1 and rd_addr[p]=0: returns 0, no bypass.
// - BYPASS=1, wr_en=1 and wr_addr==rd_addr[p] (and the write is not dropped):
//   rd_data[p] = wr_data in the same cycle.
// - Read ports are fully independent; any number may address the same register.
// Scoreboard
// - busy_set=1 at an edge sets busy[busy_addr].
// - wr_en=1 at an edge clears busy[wr_addr].
// - Both at the same edge to the same index: the set wins, so busy stays 1
//   (a new producer has been issued).
// - Both at the same edge to different indices: both take effect.
// - ZERO_REG=1: busy[0] is constantly 0.
// - Setting a bit that is already busy leaves it busy; a write to a non-busy
//   register just writes.
// Arithmetic and width
// - No arithmetic; data is stored unmodified.
// - Addresses are always in range because NUM_REGS = 2**ADDR_W.
// TESTING
// - Reset: load 0x1234_5678 into r5, assert rst asynchronously between edges
//   -> dump_regs is all 0 and busy=0 before the next edge.
// - Write/read: write r7=0xDEAD_BEEF; next cycle rd_addr0=7, rd_addr1=7
//   -> both ports 0xDEAD_BEEF.
// - Zero register: wr_en, wr_addr=0, wr_data=0xFFFF_FFFF, busy_set on r0
//   -> rd r0=0, busy[0]=0, dump_regs slot 0 = 0.
// - Bypass: r3 holds 0x11; same cycle wr r3=0x22 with rd_addr0=3
//   -> rd_data0=0x22 that cycle (BYPASS=1) or 0x11 (BYPASS=0); 0x22 next cycle.
// - Scoreboard: busy_set r9 -> busy[9]=1; later wr r9 with busy_set r9 at the
//   same edge -> busy[9] stays 1; wr r9 alone -> busy[9]=0.
// - Parameter sweep: DATA_W=64, NUM_REGS=16, NUM_RD=3, random write/read
//   traffic vs reference model -> zero mismatches over 10k cycles.

Source files
------------

// File: rtl/regfile_bank.sv
// regfile_bank: parametrised register bank with bypass,
// zero register, busy scoreboard and full-state dump.
module regfile_bank #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  input  logic                       busy_set,
  input  logic [ADDR_W-1:0]          busy_addr,
  output logic [NUM_REGS-1:0]        busy,
  output logic [NUM_REGS*DATA_W-1:0] dump_regs
);

  localparam bit ZR = (ZERO_REG != 0);
  localparam bit BP = (BYPASS != 0);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic                w_wr_ok;

  // a write to the hardwired zero register is dropped
  assign w_wr_ok = wr_en && !(ZR && (wr_addr == '0));

  // register storage, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  // scoreboard next state: write clears, a new issue wins
  always_comb begin
    w_busy_nxt = r_busy;
    if (wr_en) begin
      w_busy_nxt[wr_addr] = 1'b0;
    end
    if (busy_set) begin
      w_busy_nxt[busy_addr] = 1'b1;
    end
    if (ZR) begin
      w_busy_nxt[0] = 1'b0;
    end
  end

  // scoreboard register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign busy = r_busy;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_dump
    assign dump_regs[i*DATA_W +: DATA_W] = r_regs[i];
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic [DATA_W-1:0] w_rd;

    assign w_ra = rd_addr[p*ADDR_W +: ADDR_W];

    // read mux: zero reg, then same-cycle forward, then storage
    always_comb begin
      w_rd = r_regs[w_ra];
      if (ZR && (w_ra == '0)) begin
        w_rd = '0;
      end else if (BP && w_wr_ok && (wr_addr == w_ra)) begin
        w_rd = wr_data;
      end
    end

    assign rd_data[p*DATA_W +: DATA_W] = w_rd;
  end

endmodule

// File: tb/tb_regfile_bank.sv
// tb_regfile_bank: directed checks on the default bank and a
// no-bypass bank, plus random traffic on a 64x16x3 bank.
module tb_regfile_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // default bank
  logic          a_rst, a_wr_en, a_busy_set;
  logic [4:0]    a_wr_addr, a_busy_addr;
  logic [31:0]   a_wr_data;
  logic [9:0]    a_rd_addr;
  logic [63:0]   a_rd_data;
  logic [31:0]   a_busy;
  logic [1023:0] a_dump;

  regfile_bank u_a (
    .clk(clk), .rst(a_rst), .wr_en(a_wr_en),
    .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .rd_addr(a_rd_addr), .rd_data(a_rd_data),
    .busy_set(a_busy_set), .busy_addr(a_busy_addr),
    .busy(a_busy), .dump_regs(a_dump)
  );

  // sweep bank
  logic          b_rst, b_wr_en, b_busy_set;
  logic [3:0]    b_wr_addr, b_busy_addr;
  logic [63:0]   b_wr_data;
  logic [11:0]   b_rd_addr;
  logic [191:0]  b_rd_data;
  logic [15:0]   b_busy;
  logic [1023:0] b_dump;

  regfile_bank #(
    .DATA_W(64), .NUM_REGS(16), .NUM_RD(3)
  ) u_b (
    .clk(clk), .rst(b_rst), .wr_en(b_wr_en),
    .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .busy_set(b_busy_set), .busy_addr(b_busy_addr),
    .busy(b_busy), .dump_regs(b_dump)
  );

  // no bypass, no zero register
  logic          c_rst, c_wr_en, c_busy_set;
  logic [2:0]    c_wr_addr, c_busy_addr, c_rd_addr;
  logic [31:0]   c_wr_data, c_rd_data;
  logic [7:0]    c_busy;
  logic [255:0]  c_dump;

  regfile_bank #(
    .DATA_W(32), .NUM_REGS(8), .NUM_RD(1),
    .BYPASS(0), .ZERO_REG(0)
  ) u_c (
    .clk(clk), .rst(c_rst), .wr_en(c_wr_en),
    .wr_addr(c_wr_addr), .wr_data(c_wr_data),
    .rd_addr(c_rd_addr), .rd_data(c_rd_data),
    .busy_set(c_busy_set), .busy_addr(c_busy_addr),
    .busy(c_busy), .dump_regs(c_dump)
  );

  // reference model for the sweep bank
  logic [63:0] m_reg  [16];
  bit          m_busy [16];

  function automatic logic [63:0] b_exp_rd(input logic [3:0] a);
    if (a == 4'd0) return 64'd0;
    if (b_wr_en && b_wr_addr == a) return b_wr_data;
    return m_reg[a];
  endfunction

  function automatic logic [15:0] b_exp_busy();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = m_busy[i];
    return v;
  endfunction

  initial begin
    a_rst = 1; a_wr_en = 0; a_busy_set = 0;
    a_wr_addr = 0; a_busy_addr = 0; a_wr_data = 0;
    a_rd_addr = 0;
    b_rst = 1; b_wr_en = 0; b_busy_set = 0;
    b_wr_addr = 0; b_busy_addr = 0; b_wr_data = 0;
    b_rd_addr = 0;
    c_rst = 1; c_wr_en = 0; c_busy_set = 0;
    c_wr_addr = 0; c_busy_addr = 0; c_wr_data = 0;
    c_rd_addr = 0;
    for (int i = 0; i < 16; i++) begin
      m_reg[i] = 0; m_busy[i] = 0;
    end

    #3;
    chk("rst_busy", 64'(a_busy), 0);
    chk("rst_rd", a_rd_data, 0);
    chk("rst_dump", 64'(|a_dump), 0);
    step();
    a_rst = 0; b_rst = 0; c_rst = 0;

    // load r5 and mark r4, then async reset mid-cycle
    a_wr_en = 1; a_wr_addr = 5; a_wr_data = 32'h1234_5678;
    a_busy_set = 1; a_busy_addr = 4;
    step();
    a_wr_en = 0; a_busy_set = 0;
    #1;
    chk("wr_r5", 64'(a_dump[5*32 +: 32]), 64'h1234_5678);
    chk("busy4", 64'(a_busy[4]), 1);
    a_rst = 1;
    #1;
    chk("arst_busy", 64'(a_busy), 0);
    chk("arst_dump", 64'(|a_dump), 0);

    // forward during reset, write suppressed
    a_wr_en = 1; a_wr_addr = 6; a_wr_data = 32'hCAFE_0006;
    a_rd_addr = {5'd5, 5'd6};
    #1;
    chk("rst_byp0", 64'(a_rd_data[31:0]), 64'hCAFE_0006);
    chk("rst_byp1", 64'(a_rd_data[63:32]), 0);
    step();
    a_wr_en = 0; a_rst = 0;
    #1;
    chk("rst_nowr", 64'(a_dump[6*32 +: 32]), 0);
    chk("rst_rd6", 64'(a_rd_data[31:0]), 0);

    // write then dual read
    a_wr_en = 1; a_wr_addr = 7; a_wr_data = 32'hDEAD_BEEF;
    step();
    a_wr_en = 0; a_rd_addr = {5'd7, 5'd7};
    #1;
    chk("rd7_p0", 64'(a_rd_data[31:0]), 64'hDEAD_BEEF);
    chk("rd7_p1", 64'(a_rd_data[63:32]), 64'hDEAD_BEEF);

    // zero register
    a_wr_en = 1; a_wr_addr = 0; a_wr_data = 32'hFFFF_FFFF;
    a_busy_set = 1; a_busy_addr = 0; a_rd_addr = 0;
    #1;
    chk("z_nobyp", 64'(a_rd_data[31:0]), 0);
    step();
    a_wr_en = 0; a_busy_set = 0;
    #1;
    chk("z_rd", 64'(a_rd_data[31:0]), 0);
    chk("z_busy", 64'(a_busy[0]), 0);
    chk("z_dump", 64'(a_dump[31:0]), 0);

    // bypass
    a_wr_en = 1; a_wr_addr = 3; a_wr_data = 32'h11;
    step();
    a_wr_data = 32'h22; a_rd_addr = {5'd0, 5'd3};
    #1;
    chk("byp_same", 64'(a_rd_data[31:0]), 64'h22);
    step();
    a_wr_en = 0;
    #1;
    chk("byp_next", 64'(a_rd_data[31:0]), 64'h22);

    // scoreboard
    a_busy_set = 1; a_busy_addr = 9;
    step();
    a_busy_set = 0;
    chk("sb_set", 64'(a_busy[9]), 1);
    a_wr_en = 1; a_wr_addr = 9; a_wr_data = 32'h99;
    a_busy_set = 1; a_busy_addr = 9;
    step();
    a_busy_set = 0;
    chk("sb_setwins", 64'(a_busy[9]), 1);
    chk("sb_wr9", 64'(a_dump[9*32 +: 32]), 64'h99);
    step();
    a_wr_en = 0;
    chk("sb_clr", 64'(a_busy[9]), 0);
    a_busy_set = 1; a_busy_addr = 11;
    step();
    a_busy_addr = 10;
    a_wr_en = 1; a_wr_addr = 11; a_wr_data = 32'hB;
    step();
    a_wr_en = 0; a_busy_set = 0;
    chk("sb_both10", 64'(a_busy[10]), 1);
    chk("sb_both11", 64'(a_busy[11]), 0);

    // no-bypass, writable r0
    c_wr_en = 1; c_wr_addr = 3; c_wr_data = 32'h11;
    step();
    c_wr_data = 32'h22; c_rd_addr = 3;
    #1;
    chk("c_nobyp", 64'(c_rd_data), 64'h11);
    step();
    c_wr_en = 0;
    chk("c_next", 64'(c_rd_data), 64'h22);
    c_wr_en = 1; c_wr_addr = 0; c_wr_data = 32'hABC;
    c_busy_set = 1; c_busy_addr = 0;
    step();
    c_wr_en = 0; c_busy_set = 0; c_rd_addr = 0;
    #1;
    chk("c_r0", 64'(c_rd_data), 64'hABC);
    chk("c_busy0", 64'(c_busy[0]), 1);

    // random traffic on the sweep bank
    for (int n = 0; n < 10000; n++) begin
      b_rst       = ($urandom_range(0, 499) == 0);
      b_wr_en     = 1'($urandom_range(0, 1));
      b_wr_addr   = 4'($urandom_range(0, 15));
      b_wr_data   = {$urandom, $urandom};
      b_rd_addr   = 12'($urandom);
      b_busy_set  = 1'($urandom_range(0, 1));
      b_busy_addr = 4'($urandom_range(0, 15));
      if (b_rst) begin
        for (int i = 0; i < 16; i++) begin
          m_reg[i] = 0; m_busy[i] = 0;
        end
      end
      #2;
      for (int p = 0; p < 3; p++) begin
        chk($sformatf("b_rd%0d", p), b_rd_data[p*64 +: 64],
            b_exp_rd(b_rd_addr[p*4 +: 4]));
      end
      chk("b_busy", 64'(b_busy), 64'(b_exp_busy()));
      for (int i = 0; i < 16; i++) begin
        chk($sformatf("b_dump%0d", i), b_dump[i*64 +: 64], m_reg[i]);
      end
      @(posedge clk);
      if (!b_rst) begin
        if (b_wr_en) begin
          if (b_wr_addr != 0) m_reg[b_wr_addr] = b_wr_data;
          m_busy[b_wr_addr] = 0;
        end
        if (b_busy_set && b_busy_addr != 0) m_busy[b_busy_addr] = 1;
      end
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
